// File: rtl/npem_register_block_if.sv
// Register-bus and enclosure-command signal bundle for npem_register_block.
// The slave modport is the register block; the master modport is the
// config-space decoder plus enclosure controller side.
interface npem_register_block_if;
  logic [1:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;
  logic        encl_cmd_valid;
  logic [31:0] encl_cmd_data;
  logic        encl_cmd_ready;
  logic        encl_done;
  logic [7:0]  encl_status;
  logic        irq;

  modport slave (
    input  reg_addr, reg_wr_en, reg_wr_data, encl_cmd_ready, encl_done, encl_status,
    output reg_rd_data, encl_cmd_valid, encl_cmd_data, irq
  );

  modport master (
    output reg_addr, reg_wr_en, reg_wr_data, encl_cmd_ready, encl_done, encl_status,
    input  reg_rd_data, encl_cmd_valid, encl_cmd_data, irq
  );
endinterface

// File: rtl/npem_register_block.sv
// NPEM extended-capability register block: Capability / Control / Status.
// Accepted Control writes are forwarded to the enclosure controller as a
// valid/ready command; completion sets the Command Completed status bit and
// can raise a level interrupt.
// Optional feature macro: NPEM_CMD_TIMEOUT_EN adds a completion timeout
// counter and the Timeout status bit (bit2). Without it, a command waits for
// encl_done indefinitely and Status bit2 reads 0.
module npem_register_block #(
  parameter int unsigned REGISTER_WIDTH  = 32,
  parameter logic [31:0] HW_CAPABILITIES = 32'h0000_0FFF,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input logic                    clk,
  input logic                    rst,
  npem_register_block_if.slave   bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Capability as seen by software: OK/Locate/Fail/Rebuild are mandatory when
  // NPEM is supported; the whole register is zero when it is not.
  localparam logic [31:0] CAP_EFF = HW_CAPABILITIES[0] ?
                                    (HW_CAPABILITIES | 32'h0000_003C) : 32'h0;
  // Bits retained in Control: capability-gated indications and enclosure
  // bits, Enable and CC interrupt enable gated by NPEM capable. Initiate
  // Reset is never retained.
  localparam logic [31:0] CTRL_MASK = CAP_EFF[0] ?
    {CAP_EFF[31:24], 11'b0, 1'b1, CAP_EFF[11:2], 1'b0, 1'b1} : 32'h0;
  // The command additionally carries Initiate Reset so the enclosure sees it.
  localparam logic [31:0] CMD_MASK = CTRL_MASK | {30'b0, CAP_EFF[0], 1'b0};

  if (REGISTER_WIDTH != 32) begin : g_width_chk
    $error("npem_register_block: REGISTER_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $error("npem_register_block: TIMEOUT_CYCLES must be >= 2");
  end

  // RW1C sticky bit where a hardware set beats a software clear.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

  state_t                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [REGISTER_WIDTH-1:0] cmd_q, cmd_d;
  logic [2:0]                sts_q, sts_d;
  logic                      ctrl_wr, sts_wr;
  logic                      done_evt, drop_evt;

`ifdef NPEM_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_evt;
`endif

  assign ctrl_wr = bus_if.reg_wr_en && (bus_if.reg_addr == 2'd1) && CAP_EFF[0];
  assign sts_wr  = bus_if.reg_wr_en && (bus_if.reg_addr == 2'd2);

  // Command FSM next state, Control/command capture and completion events.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cmd_d    = cmd_q;
    done_evt = 1'b0;
    drop_evt = 1'b0;
`ifdef NPEM_CMD_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_evt  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ctrl_wr) begin
          ctrl_d  = bus_if.reg_wr_data & CTRL_MASK;
          cmd_d   = bus_if.reg_wr_data & CMD_MASK;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        drop_evt = ctrl_wr;
        if (bus_if.encl_cmd_ready) begin
          state_d = WAIT;
`ifdef NPEM_CMD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        drop_evt = ctrl_wr;
        if (bus_if.encl_done) begin
          done_evt = 1'b1;
          state_d  = IDLE;
        end
`ifdef NPEM_CMD_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          done_evt = 1'b1;
          tmo_evt  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Status next value: hardware sets win over same-cycle RW1C clears.
  always_comb begin
    sts_d    = sts_q;
    sts_d[0] = sticky_next(sts_q[0], done_evt, sts_wr & bus_if.reg_wr_data[0]);
    sts_d[1] = sticky_next(sts_q[1], drop_evt, sts_wr & bus_if.reg_wr_data[1]);
`ifdef NPEM_CMD_TIMEOUT_EN
    sts_d[2] = sticky_next(sts_q[2], tmo_evt, sts_wr & bus_if.reg_wr_data[2]);
`else
    sts_d[2] = 1'b0;
`endif
  end

  // State, Control, command and Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      cmd_q   <= '0;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cmd_q   <= cmd_d;
      sts_q   <= sts_d;
    end
  end

`ifdef NPEM_CMD_TIMEOUT_EN
  // Completion timeout counter; stops at TO_LAST because WAIT exits there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus_if.encl_cmd_valid = (state_q == ISSUE);
  assign bus_if.encl_cmd_data  = cmd_q;
  assign bus_if.irq            = sts_q[0] & ctrl_q[12] & ctrl_q[0];

  // Combinational register read mux; reserved address reads zero.
  always_comb begin
    bus_if.reg_rd_data = '0;
    case (bus_if.reg_addr)
      2'd0:    bus_if.reg_rd_data = CAP_EFF;
      2'd1:    bus_if.reg_rd_data = ctrl_q;
      2'd2:    bus_if.reg_rd_data = {bus_if.encl_status, 21'b0, sts_q};
      default: bus_if.reg_rd_data = '0;
    endcase
  end

endmodule
